axil_regbank: RTL and testbench

- Parametrised AXI4-Lite slave register bank; next generation of the coprocessor's host-facing front end.
- Replaces the fixed 5-bit/32-register/32-bit path with configurable depth and width.
- Decouples AW and W capture, merges write strobes per byte lane, and returns SLVERR for out-of-range accesses.
- Presents a flat register image plus per-register write pulses to the decode/compute logic.

---
 rtl/axil_pkg.sv | 35 +++
 rtl/axil_strb_merge.sv | 17 +
 rtl/axil_regbank.sv | 218 +++++++++++++++++++++
 tb/tb_axil_regbank.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared types, response codes and byte-lane merge helper for the AXI4-Lite register banks.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int MAX_DATA_W = 64;
  localparam int MAX_STRB_W = MAX_DATA_W / 8;

  typedef enum logic [1:0] {
    W_IDLE,
    W_COMMIT,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

  // Operates at the widest supported word; narrower callers zero-extend and truncate.
  function automatic logic [MAX_DATA_W-1:0] strb_merge(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_STRB_W-1:0] strb
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_word;
    for (int b = 0; b < MAX_STRB_W; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_strb_merge.sv
// Combinational byte-lane merge: strobed lanes take the new word, the rest keep the old one.
module axil_strb_merge
  import axil_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_word,
  input  logic [DATA_W-1:0]   new_word,
  input  logic [DATA_W/8-1:0] strb,
  output logic [DATA_W-1:0]   merged
);

  assign merged = DATA_W'(strb_merge(MAX_DATA_W'(old_word),
                                     MAX_DATA_W'(new_word),
                                     MAX_STRB_W'(strb)));

endmodule

// File: rtl/axil_regbank.sv
// Parametrised AXI4-Lite slave register bank with flat register image and per-register write pulses.
// Define AXIL_HW_WRITE_EN to add the compute-unit writeback port (hw_we/hw_idx/hw_wdata/hw_drop).
//
// state    | meaning
// W_IDLE   | accepting AW and W independently into holding registers
// W_COMMIT | both held; merge into register, pulse wr_pulse
// W_RESP   | bvalid/bresp held until bready
// R_IDLE   | accepting a read address
// R_DATA   | rvalid/rdata/rresp held until rready
module axil_regbank
  import axil_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                N_REGS    = 32,
  parameter int                ADDR_W    = 7,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        s_axi_awaddr,
  input  logic                     s_axi_awvalid,
  output logic                     s_axi_awready,
  input  logic [DATA_W-1:0]        s_axi_wdata,
  input  logic [DATA_W/8-1:0]      s_axi_wstrb,
  input  logic                     s_axi_wvalid,
  output logic                     s_axi_wready,
  output logic [1:0]               s_axi_bresp,
  output logic                     s_axi_bvalid,
  input  logic                     s_axi_bready,
  input  logic [ADDR_W-1:0]        s_axi_araddr,
  input  logic                     s_axi_arvalid,
  output logic                     s_axi_arready,
  output logic [DATA_W-1:0]        s_axi_rdata,
  output logic [1:0]               s_axi_rresp,
  output logic                     s_axi_rvalid,
  input  logic                     s_axi_rready,
`ifdef AXIL_HW_WRITE_EN
  input  logic                     hw_we,
  input  logic [7:0]               hw_idx,
  input  logic [DATA_W-1:0]        hw_wdata,
  output logic                     hw_drop,
`endif
  output logic [N_REGS*DATA_W-1:0] reg_q,
  output logic [N_REGS-1:0]        wr_pulse
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_W - LSB;
  localparam int REG_IW = (N_REGS > 1) ? $clog2(N_REGS) : 1;

  logic [DATA_W-1:0] regs [N_REGS];

  wr_state_e w_state_q, w_state_d;
  rd_state_e r_state_q, r_state_d;

  // Holds readies low through reset and releases them on the first edge with rst low.
  logic ready_en;

  logic              aw_held, w_held;
  logic [IDX_W-1:0]  aw_idx_q;
  logic [DATA_W-1:0] w_data_q;
  logic [STRB_W-1:0] w_strb_q;

  logic              commit, w_in_range;
  logic [REG_IW-1:0] w_ridx;
  logic [DATA_W-1:0] w_old, w_merged;

  logic [IDX_W-1:0]  r_idx;
  logic [REG_IW-1:0] r_ridx;
  logic              r_in_range, rd_hs;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s_axi_awaddr[LSB-1:0], s_axi_araddr[LSB-1:0]};

  assign commit     = (w_state_q == W_COMMIT);
  assign w_in_range = 32'(aw_idx_q) < N_REGS;
  assign w_ridx     = aw_idx_q[REG_IW-1:0];
  assign w_old      = regs[w_ridx];

  assign r_idx      = s_axi_araddr[ADDR_W-1:LSB];
  assign r_in_range = 32'(r_idx) < N_REGS;
  assign r_ridx     = r_idx[REG_IW-1:0];
  assign rd_hs      = s_axi_arvalid && s_axi_arready;

  axil_strb_merge #(.DATA_W(DATA_W)) u_strb_merge (
    .old_word (w_old),
    .new_word (w_data_q),
    .strb     (w_strb_q),
    .merged   (w_merged)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_en  <= 1'b0;
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
    end else begin
      ready_en  <= 1'b1;
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
    end
  end

  always_comb begin
    w_state_d     = w_state_q;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    wr_pulse      = '0;
    case (w_state_q)
      W_IDLE: begin
        s_axi_awready = ready_en && !aw_held;
        s_axi_wready  = ready_en && !w_held;
        if (aw_held && w_held) w_state_d = W_COMMIT;
      end
      W_COMMIT: begin
        if (w_in_range) wr_pulse[w_ridx] = 1'b1;
        w_state_d = W_RESP;
      end
      W_RESP: begin
        if (s_axi_bvalid && s_axi_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d     = r_state_q;
    s_axi_arready = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        s_axi_arready = ready_en;
        if (s_axi_arvalid && ready_en) r_state_d = R_DATA;
      end
      R_DATA: begin
        if (s_axi_rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_idx_q     <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
    end else begin
      if (s_axi_awvalid && s_axi_awready) begin
        aw_held  <= 1'b1;
        aw_idx_q <= s_axi_awaddr[ADDR_W-1:LSB];
      end
      if (s_axi_wvalid && s_axi_wready) begin
        w_held   <= 1'b1;
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb;
      end
      if (commit) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= w_in_range ? RESP_OKAY : RESP_SLVERR;
      end
      if (w_state_q == W_RESP && s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
      end
    end
  end

  // Reads sample regs before this edge's commit lands, so a colliding read returns the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= RESP_OKAY;
    end else if (r_state_q == R_IDLE && rd_hs) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata  <= r_in_range ? regs[r_ridx] : '0;
      s_axi_rresp  <= r_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (r_state_q == R_DATA && s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

`ifdef AXIL_HW_WRITE_EN
  logic              hw_in_range, hw_collide, hw_apply;
  logic [REG_IW-1:0] hw_ridx;

  assign hw_in_range = 32'(hw_idx) < N_REGS;
  assign hw_ridx     = hw_idx[REG_IW-1:0];
  assign hw_collide  = commit && w_in_range && (w_ridx == hw_ridx);
  assign hw_apply    = hw_we && hw_in_range && !hw_collide;

  always_ff @(posedge clk) begin
    if (rst) hw_drop <= 1'b0;
    else     hw_drop <= hw_we && !(hw_in_range && !hw_collide);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REGS; i++) regs[i] <= RESET_VAL;
    end else begin
`ifdef AXIL_HW_WRITE_EN
      if (hw_apply) regs[hw_ridx] <= hw_wdata;
`endif
      if (commit && w_in_range) regs[w_ridx] <= w_merged;
    end
  end

  for (genvar gi = 0; gi < N_REGS; gi++) begin : g_img
    assign reg_q[gi*DATA_W +: DATA_W] = regs[gi];
  end

endmodule

// File: tb/tb_axil_regbank.sv
// Self-checking bench for axil_regbank: directed scenarios plus randomized traffic against an array model.
module tb_axil_regbank;

  localparam int          DW  = 32;
  localparam int          NR  = 16;
  localparam int          AWD = 7;
  localparam logic [31:0] RV  = 32'h0BAD_F00D;

  logic           clk = 1'b0;
  logic           rst;
  logic [AWD-1:0] s_axi_awaddr;
  logic           s_axi_awvalid, s_axi_awready;
  logic [DW-1:0]  s_axi_wdata;
  logic [3:0]     s_axi_wstrb;
  logic           s_axi_wvalid, s_axi_wready;
  logic [1:0]     s_axi_bresp;
  logic           s_axi_bvalid, s_axi_bready;
  logic [AWD-1:0] s_axi_araddr;
  logic           s_axi_arvalid, s_axi_arready;
  logic [DW-1:0]  s_axi_rdata;
  logic [1:0]     s_axi_rresp;
  logic           s_axi_rvalid, s_axi_rready;
  logic [NR*DW-1:0] reg_q;
  logic [NR-1:0]    wr_pulse;
`ifdef AXIL_HW_WRITE_EN
  logic           hw_we;
  logic [7:0]     hw_idx;
  logic [DW-1:0]  hw_wdata;
  logic           hw_drop;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] model [NR];

  always #5 clk = ~clk;

  axil_regbank #(.DATA_W(DW), .N_REGS(NR), .ADDR_W(AWD), .RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
`ifdef AXIL_HW_WRITE_EN
    .hw_we(hw_we), .hw_idx(hw_idx), .hw_wdata(hw_wdata), .hw_drop(hw_drop),
`endif
    .reg_q(reg_q), .wr_pulse(wr_pulse)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_image(input string tag);
    for (int i = 0; i < NR; i++)
      chk($sformatf("%s_reg%0d", tag, i), 64'(reg_q[i*DW +: DW]), 64'(model[i]));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctl"}, {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid,
                        s_axi_rvalid, s_axi_bresp, s_axi_rresp}, 64'(0));
    chk({tag, "_rdata"}, s_axi_rdata, 64'(0));
    chk({tag, "_wr_pulse"}, wr_pulse, 64'(0));
    check_image(tag);
  endtask

  // Starts and ends on a falling edge; aw_dly/w_dly delay each valid, b_dly holds bready low.
  task automatic axi_write(input int addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly);
    int idx, lat, npulse;
    bit in_rng, aw_done, w_done, hs_aw, hs_w;
    logic [NR-1:0] pseen;
    logic [31:0] mask;
    idx = addr / 4;
    in_rng = idx < NR;
    aw_done = 0; w_done = 0; npulse = 0; pseen = '0;
    for (int c = 0; c < 40 && !(aw_done && w_done); c++) begin
      s_axi_awaddr  = AWD'(addr);
      s_axi_awvalid = !aw_done && c >= aw_dly;
      s_axi_wdata   = data;
      s_axi_wstrb   = strb;
      s_axi_wvalid  = !w_done && c >= w_dly;
      hs_aw = s_axi_awvalid && s_axi_awready;
      hs_w  = s_axi_wvalid && s_axi_wready;
      @(negedge clk);
      if (wr_pulse != '0) begin npulse++; pseen |= wr_pulse; end
      aw_done |= hs_aw;
      w_done  |= hs_w;
    end
    s_axi_awvalid = 0;
    s_axi_wvalid  = 0;
    chk("aw_w_handshake", {aw_done, w_done}, 64'h3);
    lat = 0;
    while (!s_axi_bvalid && lat < 20) begin
      @(negedge clk);
      lat++;
      if (wr_pulse != '0) begin npulse++; pseen |= wr_pulse; end
    end
    chk("b_latency", lat, 2);
    chk("bresp", s_axi_bresp, in_rng ? 2'b00 : 2'b10);
    for (int k = 0; k < b_dly; k++) begin
      @(negedge clk);
      chk("bvalid_hold", {s_axi_bvalid, s_axi_bresp}, {1'b1, in_rng ? 2'b00 : 2'b10});
    end
    s_axi_bready = 1;
    @(negedge clk);
    s_axi_bready = 0;
    chk("bvalid_clear", s_axi_bvalid, 0);
    if (in_rng) begin
      mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
      model[idx] = (model[idx] & ~mask) | (data & mask);
    end
    chk("wr_pulse_count", npulse, in_rng ? 1 : 0);
    chk("wr_pulse_bit", pseen, in_rng ? (64'(1) << idx) : 64'(0));
    check_image("wr");
  endtask

  task automatic axi_read(input int addr, input int r_dly);
    int idx, c;
    bit in_rng;
    logic [31:0] exp_d;
    idx = addr / 4;
    in_rng = idx < NR;
    s_axi_araddr  = AWD'(addr);
    s_axi_arvalid = 1;
    c = 0;
    while (!s_axi_arready && c < 20) begin @(negedge clk); c++; end
    exp_d = in_rng ? model[idx] : 32'h0;
    @(negedge clk);
    s_axi_arvalid = 0;
    chk("rvalid", s_axi_rvalid, 1);
    chk("rdata", s_axi_rdata, exp_d);
    chk("rresp", s_axi_rresp, in_rng ? 2'b00 : 2'b10);
    for (int k = 0; k < r_dly; k++) begin
      @(negedge clk);
      chk("rvalid_hold", {s_axi_rvalid, s_axi_rdata}, {1'b1, exp_d});
    end
    s_axi_rready = 1;
    @(negedge clk);
    s_axi_rready = 0;
    chk("rvalid_clear", s_axi_rvalid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1;
    s_axi_awaddr = '0; s_axi_awvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 0;
    s_axi_bready = 0; s_axi_araddr = '0; s_axi_arvalid = 0; s_axi_rready = 0;
`ifdef AXIL_HW_WRITE_EN
    hw_we = 0; hw_idx = '0; hw_wdata = '0;
`endif
    for (int i = 0; i < NR; i++) model[i] = RV;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 0;
    @(negedge clk);
    chk("ready_after_reset", {s_axi_awready, s_axi_wready, s_axi_arready}, 64'h7);

    // AW first, W two cycles later, bready held low three cycles
    axi_write(8, 32'hDEAD_BEEF, 4'hF, 0, 2, 3);
    chk("reg2_value", 64'(reg_q[2*DW +: DW]), 64'hDEAD_BEEF);

    // W before AW with partial strobes
    axi_write(0, 32'hAABB_CCDD, 4'hF, 0, 0, 0);
    axi_write(0, 32'h1122_3344, 4'b0101, 2, 0, 0);
    chk("reg0_merge", 64'(reg_q[DW-1:0]), 64'hAA22_CC44);

    // Out-of-range write and read
    axi_write(32'h7C, 32'h1234_5678, 4'hF, 0, 0, 1);
    axi_read(32'h7C, 0);
    axi_read(8, 1);

    // Read sampled on the commit edge of the same register returns the old value
    axi_write(12, 32'h9, 4'hF, 0, 0, 0);
    s_axi_awaddr = AWD'(12); s_axi_awvalid = 1;
    s_axi_wdata = 32'h5; s_axi_wstrb = 4'hF; s_axi_wvalid = 1;
    @(negedge clk);
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    @(negedge clk);
    chk("collide_pulse", wr_pulse, 64'(1) << 3);
    s_axi_araddr = AWD'(12); s_axi_arvalid = 1;
    @(negedge clk);
    s_axi_arvalid = 0;
    chk("collide_valids", {s_axi_rvalid, s_axi_bvalid}, 64'h3);
    chk("collide_rdata", s_axi_rdata, 32'h9);
    model[3] = 32'h5;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("collide_rhold", {s_axi_rvalid, s_axi_rdata}, {1'b1, 32'h9});
    end
    s_axi_rready = 1; s_axi_bready = 1;
    @(negedge clk);
    s_axi_rready = 0; s_axi_bready = 0;
    chk("collide_clear", {s_axi_rvalid, s_axi_bvalid}, 64'h0);
    check_image("collide");
    axi_read(12, 0);

    // Reset with bvalid and rvalid pending and AW/W held
    s_axi_awaddr = AWD'(16); s_axi_awvalid = 1;
    s_axi_wdata = 32'h7777_7777; s_axi_wstrb = 4'hF; s_axi_wvalid = 1;
    s_axi_araddr = AWD'(4); s_axi_arvalid = 1;
    @(negedge clk);
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
    repeat (2) @(negedge clk);
    chk("pre_reset_valids", {s_axi_rvalid, s_axi_bvalid}, 64'h3);
    rst = 1;
    @(negedge clk);
    for (int i = 0; i < NR; i++) model[i] = RV;
    check_reset_outputs("midreset");
    rst = 0;
    @(negedge clk);
    chk("ready_after_midreset", {s_axi_awready, s_axi_wready, s_axi_arready}, 64'h7);
    axi_write(20, 32'h0F0F_F0F0, 4'hF, 1, 0, 0);
    axi_read(20, 0);

    // Randomized traffic, including out-of-range indices
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 2) != 0)
        axi_write(int'(4 * $urandom_range(0, 19) + $urandom_range(0, 3)), $urandom,
                  4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 2)));
      else
        axi_read(int'(4 * $urandom_range(0, 19) + $urandom_range(0, 3)),
                 int'($urandom_range(0, 2)));
    end

`ifdef AXIL_HW_WRITE_EN
    // hw write colliding with an AXI commit to reg[1]: AXI wins, hw_drop pulses
    s_axi_awaddr = AWD'(4); s_axi_awvalid = 1;
    s_axi_wdata = 32'hCAFE_0001; s_axi_wstrb = 4'hF; s_axi_wvalid = 1;
    @(negedge clk);
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    @(negedge clk);
    hw_we = 1; hw_idx = 8'd1; hw_wdata = 32'h0BAD_BEEF;
    @(negedge clk);
    hw_we = 0;
    model[1] = 32'hCAFE_0001;
    chk("hw_drop_collide", hw_drop, 1);
    chk("hw_collide_reg1", 64'(reg_q[DW +: DW]), 64'(model[1]));
    s_axi_bready = 1;
    @(negedge clk);
    s_axi_bready = 0;
    chk("hw_drop_one_cycle", hw_drop, 0);
    hw_we = 1; hw_idx = 8'd4; hw_wdata = 32'h4444_ABCD;
    @(negedge clk);
    hw_we = 0;
    model[4] = 32'h4444_ABCD;
    chk("hw_reg4", 64'(reg_q[4*DW +: DW]), 64'(model[4]));
    chk("hw_no_pulse", {hw_drop, wr_pulse}, 64'h0);
    hw_we = 1; hw_idx = 8'd200; hw_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    hw_we = 0;
    chk("hw_drop_range", hw_drop, 1);
    check_image("hw");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
